sha256_padder: RTL and testbench
================================

Name: sha256_padder

Overview:
- Upstream message-preparation stage for the sha256 core.
- Accepts a byte-aligned message as a stream of big-endian 32-bit words and emits 512-bit blocks in the core's `data` layout.
- Applies standard SHA-256 padding: a 0x80 marker after the last byte, zero fill, then the 64-bit big-endian bit length in words 14-15, adding an extra block when the tail does not fit.
- Used for Bitcoin header hashing: an 80-byte header produces 2 blocks.

Parameters:
- LEN_W, 64: width of the internal bit-length counter. Values below 64 are zero-extended into the length field.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- in_data  in  32  message word, big-endian; byte 0 = bits [31:24]
- in_valid  in  1  in_data valid
- in_ready  out  1  word accepted when in_valid && in_ready
- in_last  in  1  final word of the message
- in_bytes  in  2  valid bytes in the final word, MSB-aligned; 0 means 4; ignored unless in_last
- blk_data  out  512  padded block; message word j at [j*32 +: 32], word 0 first
- blk_valid  out  1  blk_data valid
- blk_ready  in  1  block consumed when blk_valid && blk_ready
- blk_last  out  1  marks the final block of the message
- busy  out  1  high from the first accepted word until the final block is consumed

Behaviour:
- Interface fixed: one clock `clk`; reset `rst` is synchronous and active-high.
- Reset: state=FILL, word index=0, length=0, buffer=0, in_ready=1, blk_valid=0, blk_last=0, busy=0, blk_data=0.
- Reset mid-operation discards any partial block and any pending output; no handshake completes in the reset cycle.
- States:
  - FILL: in_ready=1. Each accepted word is written to buffer word idx; length += 32, or 8*in_bytes (32 if 0) on the last word; idx++.
  - FILL, word 16 accepted without in_last -> EMIT, blk_last=0.
  - FILL, in_last accepted -> let B = byte count in this block (0..64).
    - B<=55: write 0x80 at byte B, zero bytes B+1..55, write the length into words 14-15 -> EMIT, blk_last=1.
    - 56<=B<=63: write 0x80 at byte B, zero the rest -> EMIT with blk_last=0, then TAIL.
    - B=64: emit unchanged -> EMIT with blk_last=0, then TAIL with 0x80 at byte 0.
  - EMIT: blk_valid=1, in_ready=0; blk_data and blk_last are held stable until blk_ready. On handshake -> FILL (idx=0, buffer cleared), or -> TAIL if a tail is pending.
  - TAIL: the following cycle, buffer = zeros, optional 0x80 at byte 0, length in words 14-15 -> EMIT, blk_last=1.
  - After a blk_last block is consumed, length clears and busy drops.
- Timing:
  - blk_valid rises the cycle after the completing word is accepted.
  - A tail block follows 1 cycle after the prior block's handshake.
  - No combinational path from blk_ready to in_ready; throughput is 1 word/cycle while filling.
- Bytes past in_bytes in the last word are masked to zero regardless of input.
- Length arithmetic wraps modulo 2^LEN_W.
- The minimum message is 1 byte; zero-length messages are not supported.

Optional Feature:
- Macro: SHA256_PADDER_DIGEST_EN.
- Defined: adds ports dig_valid (in, 1), dig_ready (out, 1) and dig_data (in, 256), for Bitcoin double-SHA.
  - dig_ready=1 only in FILL with idx=0 and not busy.
  - On handshake, the next cycle emits a single block: words 0-7 = dig_data (word 0 = dig_data[255:224]), word 8 = 0x80000000, words 9-14 = 0, word 15 = 0x00000100, with blk_last=1.
  - If in_valid and dig_valid are both high at idx=0, the digest wins and in_ready=0 that cycle.
- Undefined: no digest ports; behaviour is exactly as above.

Decomposition:
- Package sha256_pkg holds:
  - SHA-256 initial hash constants and block/word widths (BLK_W=512, WORD_W=32).
  - Padder state enum (FILL, EMIT, TAIL).
  - The padding marker constant 0x80.
- One sub-module is natural: sha256_pad_mask. It is combinational: given a word, in_bytes and a marker flag, it returns the masked word with 0x80 inserted; it is used in FILL and TAIL.

Test Plan:
- "abc": one word 0x61626300, in_bytes=3, in_last -> one block; word0=0x61626380, words1-14=0, word15=0x00000018, blk_last=1.
- 56-byte message (14 full words, last on word 13) -> block1 has words 0-13 = data, word14=0x80000000, word15=0, blk_last=0. Block2 is all zero except word15=0x000001C0, blk_last=1.
- 80-byte header (20 words) -> block1 = words 0-15, blk_last=0. Block2 has words 0-3 = data, word4=0x80000000, word15=0x00000280, blk_last=1.
- 64-byte message with blk_ready held low 10 cycles -> block1 is stable and in_ready=0 throughout. After release, block2 has word0=0x80000000, word15=0x00000200.
- Reset asserted while in EMIT with 16 words buffered -> next cycle blk_valid=0, in_ready=1, busy=0. A following "abc" message produces exactly the block from the first scenario.
- (SHA256_PADDER_DIGEST_EN) digest = 32 bytes 0x00..0x1F -> words 0-7 = 0x00010203..0x1C1D1E1F, word8=0x80000000, word15=0x00000100, blk_last=1.

Source files
------------

// File: rtl/sha256_pkg.sv
// Shared SHA-256 constants, widths, padder state encoding and the length-field helper
// used by the message padder.
package sha256_pkg;

  localparam int BLK_W     = 512;
  localparam int WORD_W    = 32;
  localparam int BLK_WORDS = 16;

  localparam logic [255:0] H_INIT = {
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  localparam logic [7:0] PAD_MARK = 8'h80;

  typedef enum logic [1:0] {
    FILL = 2'd0,
    EMIT = 2'd1,
    TAIL = 2'd2
  } pad_state_e;

  // Places the 64-bit big-endian message bit length into words 14 (high) and 15 (low).
  function automatic logic [BLK_W-1:0] put_len(input logic [BLK_W-1:0] blk,
                                               input logic [63:0] bit_len);
    logic [BLK_W-1:0] res;
    res = blk;
    res[14*WORD_W +: WORD_W] = bit_len[63:32];
    res[15*WORD_W +: WORD_W] = bit_len[31:0];
    return res;
  endfunction

endpackage

// File: rtl/sha256_pad_mask.sv
// Combinational word masker: keeps the leading message bytes of a word, zeroes the rest
// and optionally drops the 0x80 padding marker right after the kept bytes.
module sha256_pad_mask
  import sha256_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  nbytes,
  input  logic        marker,
  output logic [31:0] masked
);

  logic [7:0] mark_byte;

  assign mark_byte = marker ? PAD_MARK : 8'h00;

  // With marker clear, nbytes==0 means a full word; with marker set it means marker at byte 0.
  always_comb begin
    masked = 32'h0000_0000;
    case (nbytes)
      2'd0:    masked = marker ? {PAD_MARK, 24'h00_0000} : word;
      2'd1:    masked = {word[31:24], mark_byte, 16'h0000};
      2'd2:    masked = {word[31:16], mark_byte, 8'h00};
      2'd3:    masked = {word[31:8], mark_byte};
      default: masked = word;
    endcase
  end

endmodule

// File: rtl/sha256_padder.sv
// SHA-256 message padder: packs 32-bit words into 512-bit blocks and appends the padding.
// Optional digest re-hash input (double SHA) is enabled by defining SHA256_PADDER_DIGEST_EN.
module sha256_padder
  import sha256_pkg::*;
#(
  parameter int LEN_W = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      in_data,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_last,
  input  logic [1:0]       in_bytes,
  output logic [BLK_W-1:0] blk_data,
  output logic             blk_valid,
  input  logic             blk_ready,
  output logic             blk_last,
  output logic             busy
`ifdef SHA256_PADDER_DIGEST_EN
  ,
  input  logic             dig_valid,
  output logic             dig_ready,
  input  logic [255:0]     dig_data
`endif
);

  pad_state_e       state_r, state_s;
  logic [3:0]       idx_r, idx_s;
  logic [BLK_W-1:0] buf_r, buf_s;
  logic [LEN_W-1:0] len_r, len_s;
  logic             tail_pend_r, tail_pend_s;
  logic             tail_mark_r, tail_mark_s;
  logic             last_r, last_s;
  logic             busy_r, busy_s;

  logic             in_fire_s;
  logic             dig_fire_s;
  logic [2:0]       nb_s;
  logic [6:0]       fill_b_s;
  logic [LEN_W-1:0] len_add_s;
  logic [31:0]      m_word_s;
  logic [1:0]       m_nb_s;
  logic             m_marker_s;
  logic [31:0]      m_out_s;
  logic [BLK_W-1:0] tail_blk_s;
  logic [BLK_W-1:0] dig_blk_s;

`ifdef SHA256_PADDER_DIGEST_EN
  assign dig_ready  = (state_r == FILL) && (idx_r == 4'd0) && !busy_r;
  assign dig_fire_s = dig_valid && dig_ready;
  assign in_ready   = (state_r == FILL) && !dig_fire_s;

  // Digest block: 256-bit digest, marker word, zero fill, fixed 256-bit length.
  always_comb begin
    dig_blk_s = {BLK_W{1'b0}};
    for (int j = 0; j < 8; j++) begin
      dig_blk_s[j*WORD_W +: WORD_W] = dig_data[255 - 32*j -: 32];
    end
    dig_blk_s[8*WORD_W +: WORD_W]  = {PAD_MARK, 24'h00_0000};
    dig_blk_s[15*WORD_W +: WORD_W] = 32'h0000_0100;
  end
`else
  assign dig_fire_s = 1'b0;
  assign dig_blk_s  = {BLK_W{1'b0}};
  assign in_ready   = (state_r == FILL);
`endif

  assign in_fire_s = in_valid && in_ready;
  assign nb_s      = (in_bytes == 2'd0) ? 3'd4 : {1'b0, in_bytes};
  assign fill_b_s  = {1'b0, idx_r, 2'b00} + {4'd0, nb_s};
  assign len_add_s = in_last ? LEN_W'({nb_s, 3'b000}) : LEN_W'(6'd32);

  // The masker serves the last message word in FILL and the leading marker word in TAIL.
  always_comb begin
    m_word_s   = in_data;
    m_nb_s     = 2'd0;
    m_marker_s = 1'b0;
    if (state_r == TAIL) begin
      m_word_s   = 32'h0000_0000;
      m_nb_s     = 2'd0;
      m_marker_s = tail_mark_r;
    end else if (in_last) begin
      m_word_s   = in_data;
      m_nb_s     = in_bytes;
      m_marker_s = (in_bytes != 2'd0);
    end else begin
      m_word_s   = in_data;
      m_nb_s     = 2'd0;
      m_marker_s = 1'b0;
    end
  end

  sha256_pad_mask u_mask (
    .word   (m_word_s),
    .nbytes (m_nb_s),
    .marker (m_marker_s),
    .masked (m_out_s)
  );

  assign tail_blk_s = put_len({{(BLK_W-WORD_W){1'b0}}, m_out_s}, 64'(len_r));

  // Next-state logic for the block assembler.
  always_comb begin
    state_s     = state_r;
    idx_s       = idx_r;
    buf_s       = buf_r;
    len_s       = len_r;
    tail_pend_s = tail_pend_r;
    tail_mark_s = tail_mark_r;
    last_s      = last_r;
    busy_s      = busy_r;
    case (state_r)
      FILL: begin
        if (dig_fire_s) begin
          buf_s       = dig_blk_s;
          busy_s      = 1'b1;
          last_s      = 1'b1;
          tail_pend_s = 1'b0;
          state_s     = EMIT;
        end else if (in_fire_s) begin
          busy_s = 1'b1;
          len_s  = len_r + len_add_s;
          idx_s  = idx_r + 4'd1;
          buf_s[{idx_r, 5'b00000} +: WORD_W] = m_out_s;
          if (in_last) begin
            // A full last word pushes the marker into the next word, if the block has one.
            if ((nb_s == 3'd4) && (idx_r != 4'd15)) begin
              buf_s[{idx_s, 5'b00000} +: WORD_W] = {PAD_MARK, 24'h00_0000};
            end else begin
              buf_s[{idx_r, 5'b00000} +: WORD_W] = m_out_s;
            end
            if (fill_b_s <= 7'd55) begin
              buf_s       = put_len(buf_s, 64'(len_s));
              last_s      = 1'b1;
              tail_pend_s = 1'b0;
              tail_mark_s = 1'b0;
            end else begin
              last_s      = 1'b0;
              tail_pend_s = 1'b1;
              tail_mark_s = (fill_b_s == 7'd64);
            end
            state_s = EMIT;
          end else if (idx_r == 4'd15) begin
            last_s      = 1'b0;
            tail_pend_s = 1'b0;
            state_s     = EMIT;
          end else begin
            state_s = FILL;
          end
        end else begin
          state_s = FILL;
        end
      end
      EMIT: begin
        if (blk_ready) begin
          if (last_r) begin
            state_s = FILL;
            idx_s   = 4'd0;
            buf_s   = {BLK_W{1'b0}};
            len_s   = {LEN_W{1'b0}};
            busy_s  = 1'b0;
            last_s  = 1'b0;
          end else if (tail_pend_r) begin
            state_s     = TAIL;
            tail_pend_s = 1'b0;
          end else begin
            state_s = FILL;
            idx_s   = 4'd0;
            buf_s   = {BLK_W{1'b0}};
          end
        end else begin
          state_s = EMIT;
        end
      end
      TAIL: begin
        buf_s       = tail_blk_s;
        last_s      = 1'b1;
        tail_mark_s = 1'b0;
        state_s     = EMIT;
      end
      default: begin
        state_s = FILL;
      end
    endcase
  end

  // State register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= FILL;
      idx_r       <= 4'd0;
      buf_r       <= {BLK_W{1'b0}};
      len_r       <= {LEN_W{1'b0}};
      tail_pend_r <= 1'b0;
      tail_mark_r <= 1'b0;
      last_r      <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      state_r     <= state_s;
      idx_r       <= idx_s;
      buf_r       <= buf_s;
      len_r       <= len_s;
      tail_pend_r <= tail_pend_s;
      tail_mark_r <= tail_mark_s;
      last_r      <= last_s;
      busy_r      <= busy_s;
    end
  end

  assign blk_data  = buf_r;
  assign blk_valid = (state_r == EMIT);
  assign blk_last  = last_r;
  assign busy      = busy_r;

endmodule

// File: tb/tb_sha256_padder.sv
// Self-checking bench for sha256_padder: byte-level padding reference model, table of
// message lengths with random stalls, and directed multi-cycle sequences.
module tb_sha256_padder;

  typedef logic [7:0] u8;
  typedef struct {
    int len;
    int stall;
    int nblk;
  } tv_t;

  logic         clk = 1'b0;
  logic         rst;
  logic [31:0]  in_data;
  logic         in_valid;
  logic         in_ready;
  logic         in_last;
  logic [1:0]   in_bytes;
  logic [511:0] blk_data;
  logic         blk_valid;
  logic         blk_ready;
  logic         blk_last;
  logic         busy;
`ifdef SHA256_PADDER_DIGEST_EN
  logic         dig_valid;
  logic         dig_ready;
  logic [255:0] dig_data;
`endif

  int n_chk  = 0;
  int n_fail = 0;
  u8            msg[$];
  logic [511:0] exp_q[$];
  tv_t          tv[12];

  always #5 clk = ~clk;

  sha256_padder #(.LEN_W(64)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_last   (in_last),
    .in_bytes  (in_bytes),
    .blk_data  (blk_data),
    .blk_valid (blk_valid),
    .blk_ready (blk_ready),
    .blk_last  (blk_last),
    .busy      (busy)
`ifdef SHA256_PADDER_DIGEST_EN
    ,
    .dig_valid (dig_valid),
    .dig_ready (dig_ready),
    .dig_data  (dig_data)
`endif
  );

  task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: append 0x80, zero-fill to 56 mod 64, append 64-bit bit length, split in blocks.
  function automatic void model();
    u8 p[$];
    longint bits;
    logic [511:0] blk;
    p = msg;
    bits = longint'(msg.size()) * 8;
    p.push_back(8'h80);
    while ((p.size() % 64) != 56) p.push_back(8'h00);
    for (int i = 7; i >= 0; i--) p.push_back(u8'(bits >> (8 * i)));
    exp_q.delete();
    for (int b = 0; b < p.size() / 64; b++) begin
      blk = '0;
      for (int j = 0; j < 16; j++)
        for (int k = 0; k < 4; k++)
          blk[j*32 + (3-k)*8 +: 8] = p[b*64 + 4*j + k];
      exp_q.push_back(blk);
    end
  endfunction

  function automatic logic [31:0] msg_word(input int w);
    logic [31:0] v;
    for (int k = 0; k < 4; k++)
      v[31-8*k -: 8] = (4*w + k < msg.size()) ? msg[4*w + k] : u8'($urandom);
    return v;
  endfunction

  task automatic make_msg(input int len);
    msg.delete();
    for (int i = 0; i < len; i++) msg.push_back(u8'($urandom));
  endtask

  // Streams msg in, consumes nblk blocks and compares them to exp_q.
  task automatic run_msg(input string tag, input int stall, input int nblk);
    int nw, wi, bi, cyc;
    nw = (msg.size() + 3) / 4;
    wi = 0; bi = 0; cyc = 0;
    while (bi < nblk && cyc < 3000) begin
      if (wi < nw && $urandom_range(99) >= stall) begin
        in_valid = 1'b1;
        in_data  = msg_word(wi);
        in_last  = (wi == nw - 1);
        in_bytes = (wi == nw - 1) ? 2'(msg.size() % 4) : 2'($urandom);
      end else begin
        in_valid = 1'b0;
        in_data  = $urandom;
        in_last  = 1'b0;
      end
      blk_ready = ($urandom_range(99) >= stall);
      @(negedge clk);
      if (in_valid && in_ready) wi++;
      if (blk_valid && blk_ready) begin
        check({tag, " data"}, blk_data, (bi < exp_q.size()) ? exp_q[bi] : '0);
        check({tag, " last"}, 512'(blk_last), 512'(bi == nblk - 1));
        bi++;
      end
      @(posedge clk); #1;
      cyc++;
    end
    in_valid = 1'b0; in_last = 1'b0; blk_ready = 1'b1;
    if (cyc >= 3000) begin
      n_chk++; n_fail++;
      $display("FAIL %s timeout: got %0d blocks expected %0d", tag, bi, nblk);
    end
    @(negedge clk);
    check({tag, " busy after"}, 512'(busy), 512'(0));
    check({tag, " no extra blk"}, 512'(blk_valid), 512'(0));
    @(posedge clk); #1;
    blk_ready = 1'b0;
  endtask

  task automatic set_abc_exp();
    logic [511:0] b;
    msg.delete();
    msg.push_back(8'h61); msg.push_back(8'h62); msg.push_back(8'h63);
    b = '0;
    b[31:0]        = 32'h6162_6380;
    b[15*32 +: 32] = 32'h0000_0018;
    exp_q.delete();
    exp_q.push_back(b);
  endtask

  initial begin
    logic [511:0] b;
    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_last = 1'b0; in_bytes = '0; blk_ready = 1'b0;
`ifdef SHA256_PADDER_DIGEST_EN
    dig_valid = 1'b0; dig_data = '0;
`endif
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst in_ready", 512'(in_ready), 512'(1));
    check("rst blk_valid", 512'(blk_valid), 512'(0));
    check("rst blk_last", 512'(blk_last), 512'(0));
    check("rst busy", 512'(busy), 512'(0));
    check("rst blk_data", blk_data, '0);
    @(posedge clk); #1;

    // "abc" with exact constants
    set_abc_exp();
    run_msg("abc", 0, 1);

    // 80-byte header: explicit expected second block
    make_msg(80);
    exp_q.delete();
    b = '0;
    for (int j = 0; j < 16; j++) b[j*32 +: 32] = {msg[4*j], msg[4*j+1], msg[4*j+2], msg[4*j+3]};
    exp_q.push_back(b);
    b = '0;
    for (int j = 0; j < 4; j++) b[j*32 +: 32] = {msg[64+4*j], msg[65+4*j], msg[66+4*j], msg[67+4*j]};
    b[4*32 +: 32]  = 32'h8000_0000;
    b[15*32 +: 32] = 32'h0000_0280;
    exp_q.push_back(b);
    run_msg("hdr80", 20, 2);

    // Random lengths against the reference model
    tv[0]  = '{3, 0, 1};    tv[1]  = '{1, 30, 1};   tv[2]  = '{4, 0, 1};
    tv[3]  = '{52, 20, 1};  tv[4]  = '{55, 0, 1};   tv[5]  = '{56, 40, 2};
    tv[6]  = '{63, 0, 2};   tv[7]  = '{64, 25, 2};  tv[8]  = '{80, 0, 2};
    tv[9]  = '{119, 30, 2}; tv[10] = '{120, 10, 3}; tv[11] = '{128, 50, 3};
    for (int t = 0; t < 12; t++) begin
      make_msg(tv[t].len);
      model();
      run_msg($sformatf("len%0d", tv[t].len), tv[t].stall, tv[t].nblk);
    end

    // 64-byte message with the first block stalled for 10 cycles
    make_msg(64);
    model();
    for (int w = 0; w < 16; w++) begin
      in_valid = 1'b1; in_data = msg_word(w); in_last = (w == 15); in_bytes = 2'd0;
      @(posedge clk); #1;
    end
    in_valid = 1'b1; in_last = 1'b0; in_data = $urandom;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      check("stall valid", 512'(blk_valid), 512'(1));
      check("stall in_ready", 512'(in_ready), 512'(0));
      check("stall data", blk_data, exp_q[0]);
      check("stall last", 512'(blk_last), 512'(0));
      @(posedge clk); #1;
    end
    in_valid = 1'b0; blk_ready = 1'b1;
    @(negedge clk);
    check("stall data at release", blk_data, exp_q[0]);
    @(posedge clk); #1;
    @(negedge clk);
    check("tail gap", 512'(blk_valid), 512'(0));
    @(posedge clk); #1;
    @(negedge clk);
    check("tail valid", 512'(blk_valid), 512'(1));
    check("tail word0", 512'(blk_data[31:0]), 512'(32'h8000_0000));
    check("tail word15", 512'(blk_data[15*32 +: 32]), 512'(32'h0000_0200));
    check("tail data", blk_data, exp_q[1]);
    check("tail last", 512'(blk_last), 512'(1));
    @(posedge clk); #1;
    blk_ready = 1'b0;
    @(negedge clk);
    check("tail busy after", 512'(busy), 512'(0));
    @(posedge clk); #1;

    // Reset while a full block waits in EMIT
    for (int w = 0; w < 16; w++) begin
      in_valid = 1'b1; in_data = $urandom; in_last = 1'b0; in_bytes = 2'($urandom);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    rst = 1'b1; blk_ready = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; blk_ready = 1'b0;
    @(negedge clk);
    check("midrst blk_valid", 512'(blk_valid), 512'(0));
    check("midrst in_ready", 512'(in_ready), 512'(1));
    check("midrst busy", 512'(busy), 512'(0));
    @(posedge clk); #1;
    set_abc_exp();
    run_msg("abc after rst", 0, 1);

`ifdef SHA256_PADDER_DIGEST_EN
    for (int i = 0; i < 32; i++) dig_data[255 - 8*i -: 8] = u8'(i);
    dig_valid = 1'b1; in_valid = 1'b1; in_data = $urandom; in_last = 1'b1; in_bytes = 2'd1;
    @(negedge clk);
    check("dig ready", 512'(dig_ready), 512'(1));
    check("dig wins in_ready", 512'(in_ready), 512'(0));
    @(posedge clk); #1;
    dig_valid = 1'b0; in_valid = 1'b0; in_last = 1'b0;
    b = '0;
    for (int j = 0; j < 8; j++) b[j*32 +: 32] = 32'h0001_0203 + 32'(j) * 32'h0404_0404;
    b[8*32 +: 32]  = 32'h8000_0000;
    b[15*32 +: 32] = 32'h0000_0100;
    @(negedge clk);
    check("dig valid", 512'(blk_valid), 512'(1));
    check("dig data", blk_data, b);
    check("dig last", 512'(blk_last), 512'(1));
    blk_ready = 1'b1;
    @(posedge clk); #1;
    blk_ready = 1'b0;
    @(negedge clk);
    check("dig busy after", 512'(busy), 512'(0));
    @(posedge clk); #1;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
